// File: rtl/inst_dec_stage_if.sv
// Fetch-to-decode and decode-to-issue handshake bundle for inst_dec_stage.
// master drives the fetch side and consumer ready; slave is the stage.
interface inst_dec_stage_if #(
  parameter int PC_W = 32
);
  logic            IN_VALID;
  logic            IN_READY;
  logic [PC_W-1:0] PC_IN;
  logic [31:0]     INSTR;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [PC_W-1:0] PC_OUT;
  logic [10:0]     INST_TYPE;
  logic [2:0]      FUNCT3;
  logic [6:0]      FUNCT7;
  logic [4:0]      RS1;
  logic [4:0]      RS2;
  logic [4:0]      RD;
  logic [31:0]     IMM;
  logic            ILLEGAL;

  modport master (
    output IN_VALID, PC_IN, INSTR, OUT_READY,
    input  IN_READY, OUT_VALID, PC_OUT, INST_TYPE,
    input  FUNCT3, FUNCT7, RS1, RS2, RD, IMM, ILLEGAL
  );

  modport slave (
    input  IN_VALID, PC_IN, INSTR, OUT_READY,
    output IN_READY, OUT_VALID, PC_OUT, INST_TYPE,
    output FUNCT3, FUNCT7, RS1, RS2, RD, IMM, ILLEGAL
  );
endinterface

// File: rtl/inst_dec_stage.sv
// RV32I decode stage with a small queue of decoded entries.
// Optional INST_DEC_ILLEGAL_EN adds a per-entry illegal-instruction flag.
module inst_dec_stage #(
  parameter int PC_W   = 32,
  parameter int QDEPTH = 2
) (
  input logic             CLK,
  input logic             RESETN,
  input logic             FLUSH,
  inst_dec_stage_if.slave dec
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [10:0]     typ;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
  } ent_t;

  logic [31:0] i;
  logic [6:0]  opc;
  logic [10:0] typ;
  logic [31:0] imm;
  ent_t        ent;

  assign i   = dec.INSTR;
  assign opc = i[6:0];

  always_comb begin
    typ = '0;
    if (i[1:0] == 2'b11) begin
      case (opc)
        7'b0110111: typ[0]  = 1'b1;
        7'b0010111: typ[1]  = 1'b1;
        7'b1101111: typ[2]  = 1'b1;
        7'b1100111: typ[3]  = 1'b1;
        7'b1100011: typ[4]  = 1'b1;
        7'b0000011: typ[5]  = 1'b1;
        7'b0100011: typ[6]  = 1'b1;
        7'b0010011: typ[7]  = 1'b1;
        7'b0110011: typ[8]  = 1'b1;
        7'b0001111: typ[9]  = 1'b1;
        7'b1110011: typ[10] = 1'b1;
        default:    typ     = '0;
      endcase
    end
  end

  always_comb begin
    imm = '0;
    unique case (1'b1)
      typ[3], typ[5], typ[7], typ[9], typ[10]:
        imm = {{20{i[31]}}, i[31:20]};
      typ[6]:
        imm = {{20{i[31]}}, i[31:25], i[11:7]};
      typ[4]:
        imm = {{19{i[31]}}, i[31], i[7],
               i[30:25], i[11:8], 1'b0};
      typ[0], typ[1]:
        imm = {i[31:12], 12'b0};
      typ[2]:
        imm = {{11{i[31]}}, i[31], i[19:12],
               i[20], i[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

  assign ent = '{
    pc:  dec.PC_IN,
    typ: typ,
    f3:  i[14:12],
    f7:  i[31:25],
    rs1: i[19:15],
    rs2: i[24:20],
    rd:  i[11:7],
    imm: imm
  };

  ent_t          mem [QDEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign dec.IN_READY  = count < CW'(QDEPTH);
  assign dec.OUT_VALID = count != '0;
  assign push = dec.IN_VALID && dec.IN_READY;
  assign pop  = dec.OUT_VALID && dec.OUT_READY;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
    end else if (FLUSH) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload is not reset; it is only meaningful while OUT_VALID is high.
  always_ff @(posedge CLK) begin
    if (push && !FLUSH) mem[wptr] <= ent;
  end

  assign dec.PC_OUT    = mem[rptr].pc;
  assign dec.INST_TYPE = mem[rptr].typ;
  assign dec.FUNCT3    = mem[rptr].f3;
  assign dec.FUNCT7    = mem[rptr].f7;
  assign dec.RS1       = mem[rptr].rs1;
  assign dec.RS2       = mem[rptr].rs2;
  assign dec.RD        = mem[rptr].rd;
  assign dec.IMM       = mem[rptr].imm;

`ifdef INST_DEC_ILLEGAL_EN
  logic ill;
  logic ill_mem [QDEPTH];

  always_comb begin
    ill = 1'b0;
    if (typ == '0)
      ill = 1'b1;
    if (typ[8] && ent.f7 != 7'h00 && ent.f7 != 7'h20)
      ill = 1'b1;
    if (ent.f7 == 7'h20 && ent.f3 != 3'b000 && ent.f3 != 3'b101)
      ill = 1'b1;
    if (typ[4] && (ent.f3 == 3'b010 || ent.f3 == 3'b011))
      ill = 1'b1;
    if (typ[3] && ent.f3 != 3'b000)
      ill = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (push && !FLUSH) ill_mem[wptr] <= ill;
  end

  assign dec.ILLEGAL = ill_mem[rptr];
`else
  assign dec.ILLEGAL = 1'b0;
`endif
endmodule

// File: doc/inst_dec_stage.md
INST_DEC_STAGE -- requirements
Module: inst_dec_stage

Interface
REQ-001 Parameter PC_W, default 32: width of PC_IN and PC_OUT.
REQ-002 Parameter QDEPTH, default 2: decoded-entry queue depth; power of two, at least 2.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESETN  input  1  reset, asynchronous, active-low.
REQ-005 FLUSH  input  1  synchronous discard of all queued entries.
REQ-006 IN_VALID  input  1  fetch offers PC_IN and INSTR.
REQ-007 IN_READY  output  1  stage accepts an entry this cycle.
REQ-008 PC_IN  input  PC_W  address of INSTR.
REQ-009 INSTR  input  32  raw RV32I instruction word.
REQ-010 OUT_VALID  output  1  head entry valid.
REQ-011 OUT_READY  input  1  consumer takes the head entry.
REQ-012 PC_OUT  output  PC_W  PC of the head entry.
REQ-013 INST_TYPE  output  11  one-hot class: bit0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 ALUI, 8 ALUR, 9 FENCE, 10 SYS.
REQ-014 FUNCT3, FUNCT7, RS1, RS2, RD  outputs  3, 7, 5, 5, 5  fields INSTR[14:12], [31:25], [19:15], [24:20], [11:7].
REQ-015 IMM  output  32  sign-extended immediate for the entry's class.
REQ-016 ILLEGAL  output  1  head entry is illegal (see Configuration).

Function
REQ-017 Decode is combinational on INSTR at push; the queue stores decoded fields, never the raw word.
REQ-018 Opcode INSTR[6:0] maps to exactly one INST_TYPE bit; an unknown opcode or INSTR[1:0] != 2'b11 gives INST_TYPE = 0.
REQ-019 IMM: I-form for JALR, LOAD, ALUI, SYS, FENCE; S-form for STORE; B-form for BRANCH; U-form for LUI, AUIPC; J-form for JAL; 0 for ALUR or unknown.
REQ-020 B-form and J-form immediates have bit0 = 0; all forms sign-extend from INSTR[31].
REQ-021 Push occurs when IN_VALID && IN_READY; pop occurs when OUT_VALID && OUT_READY.
REQ-022 IN_READY = (count < QDEPTH); it does not depend combinationally on OUT_READY.
REQ-023 OUT_VALID = (count != 0); outputs always show the head entry and are held stable while OUT_VALID && !OUT_READY.
REQ-024 Latency: an entry pushed into an empty queue at edge N is presented with OUT_VALID = 1 after edge N.
REQ-025 Order is strictly FIFO; read and write pointers wrap modulo QDEPTH.
REQ-026 A simultaneous push and pop leaves count unchanged; this is legal at any count below QDEPTH.
REQ-027 FLUSH sets count and both pointers to 0 at the next edge, overriding any simultaneous push or pop; the pushed entry is dropped.
REQ-028 While count = QDEPTH, IN_READY = 0 and INSTR is ignored.

Reset
REQ-029 RESETN low immediately forces count, pointers, and OUT_VALID to 0 and IN_READY to 1, regardless of an in-flight handshake.
REQ-030 Queue payload storage is not reset; payload outputs are don't-care while OUT_VALID = 0.
REQ-031 After RESETN deasserts, the first push is accepted at the first rising edge.

Configuration
REQ-032 Macro INST_DEC_ILLEGAL_EN:
- Defined: ILLEGAL = 1 for INST_TYPE = 0.
- Defined: ILLEGAL = 1 for ALUR with FUNCT7 not in {0x00, 0x20}.
- Defined: ILLEGAL = 1 for FUNCT7 = 0x20 with FUNCT3 not in {000, 101}.
- Defined: ILLEGAL = 1 for BRANCH with FUNCT3 in {010, 011}.
- Defined: ILLEGAL = 1 for JALR with FUNCT3 != 000.
- Defined: the flag is stored per entry.
- Undefined: ILLEGAL is tied to 0 and no storage is added.

Verification
REQ-033 Push INSTR 0x00500093 (addi x1,x0,5) at PC 0x100 into an empty queue -> next cycle: OUT_VALID=1, INST_TYPE bit7, RD=1, RS1=0, IMM=0x00000005, PC_OUT=0x100.
REQ-034 Push 0xFE000EE3 (beq, offset -4) -> INST_TYPE bit4, IMM=0xFFFFFFFC; push 0x800000EF (jal) -> INST_TYPE bit2, IMM=0xFFF00000.
REQ-035 Hold OUT_READY=0 with IN_VALID=1 for QDEPTH+2 cycles -> IN_READY=0 after QDEPTH pushes; then OUT_READY=1 drains the entries in push order.
REQ-036 At count=1, push and pop in the same cycle -> count stays 1 and the new entry becomes head.
REQ-037 At count=2, assert FLUSH with IN_VALID=1 -> next cycle OUT_VALID=0 and the pushed entry is lost; assert RESETN low mid-burst -> OUT_VALID=0 immediately.
REQ-038 With INST_DEC_ILLEGAL_EN defined, push 0xFFFFFFFF -> INST_TYPE=0, ILLEGAL=1; push 0x40001033 -> ILLEGAL=1. With it undefined, both give ILLEGAL=0.
